// File: rtl/ansi_colour_decoder.sv
// ANSI SGR colour escape decoder: strips ESC '[' digits 'm' sequences and tags payload bytes with the colour in force.
// Define ANSI_DEC_STATS_EN to add saturating seq_count/err_count outputs.
module ansi_colour_decoder #(
  parameter int         MAX_DIGITS     = 3,
  parameter logic [2:0] DEFAULT_COLOUR = 3'd0,
  parameter int         CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic [2:0] out_colour,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] cur_colour,
  output logic       err_pulse
`ifdef ANSI_DEC_STATS_EN
  ,
  output logic [CNT_W-1:0] seq_count,
  output logic [CNT_W-1:0] err_count
`endif
);

  localparam int DCW = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, ESC_SEEN, PARAM} state_t;

  state_t     state_q, state_d;
  logic [9:0] acc_q, acc_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic       ovf_q, ovf_d;
  logic [7:0] out_data_q, out_data_d;
  logic [2:0] out_colour_q, out_colour_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] cur_colour_q, cur_colour_d;
  logic       err_q, err_d;

  logic        accept;
  logic        is_digit;
  logic [13:0] acc_next;
  logic        code_ok;
  logic [2:0]  code_colour;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign acc_next = ({4'd0, acc_q} * 14'd10) + {10'd0, in_data[3:0]};

  // A frozen (overflowed) parameter is never applied, whatever its value.
  always_comb begin
    code_ok     = 1'b1;
    code_colour = cur_colour_q;
    case (acc_q)
      10'd0:   code_colour = DEFAULT_COLOUR;
      10'd37:  code_colour = 3'd0;
      10'd94:  code_colour = 3'd1;
      10'd33:  code_colour = 3'd2;
      10'd31:  code_colour = 3'd3;
      10'd32:  code_colour = 3'd4;
      default: code_ok = 1'b0;
    endcase
    if (ovf_q) code_ok = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    dcnt_d       = dcnt_q;
    ovf_d        = ovf_q;
    cur_colour_d = cur_colour_q;
    err_d        = 1'b0;
    out_data_d   = out_data_q;
    out_colour_d = out_colour_q;
    out_valid_d  = out_valid_q && !out_ready;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_data == 8'h1B) begin
            state_d = ESC_SEEN;
          end else begin
            out_data_d   = in_data;
            out_colour_d = cur_colour_q;
            out_valid_d  = 1'b1;
          end
        end
        ESC_SEEN: begin
          if (in_data == 8'h5B) begin
            state_d = PARAM;
            acc_d   = '0;
            dcnt_d  = '0;
            ovf_d   = 1'b0;
          end else if (in_data == 8'h1B) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        PARAM: begin
          if (is_digit) begin
            if (dcnt_q == DCW'(MAX_DIGITS)) begin
              ovf_d = 1'b1;
            end else begin
              acc_d  = (acc_next > 14'd1023) ? 10'd1023 : acc_next[9:0];
              dcnt_d = dcnt_q + 1'b1;
            end
          end else if (in_data == 8'h6D) begin
            state_d = IDLE;
            if (code_ok) cur_colour_d = code_colour;
            else         err_d = 1'b1;
          end else if (in_data == 8'h1B) begin
            err_d   = 1'b1;
            state_d = ESC_SEEN;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      dcnt_q       <= '0;
      ovf_q        <= 1'b0;
      out_data_q   <= '0;
      out_colour_q <= DEFAULT_COLOUR;
      out_valid_q  <= 1'b0;
      cur_colour_q <= DEFAULT_COLOUR;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      dcnt_q       <= dcnt_d;
      ovf_q        <= ovf_d;
      out_data_q   <= out_data_d;
      out_colour_q <= out_colour_d;
      out_valid_q  <= out_valid_d;
      cur_colour_q <= cur_colour_d;
      err_q        <= err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_colour = out_colour_q;
  assign out_valid  = out_valid_q;
  assign cur_colour = cur_colour_q;
  assign err_pulse  = err_q;

`ifdef ANSI_DEC_STATS_EN
  logic [CNT_W-1:0] seq_cnt_q, err_cnt_q;
  logic             seq_ev;

  assign seq_ev = accept && (state_q == PARAM) && (in_data == 8'h6D) && code_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (seq_ev && (seq_cnt_q != '1)) seq_cnt_q <= seq_cnt_q + 1'b1;
      if (err_d && (err_cnt_q != '1))  err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign seq_count = seq_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ansi_colour_decoder.sv
// Directed bench for ansi_colour_decoder: byte sequences with hand-computed tagged outputs and error counts.
module tb_ansi_colour_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_colour;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] cur_colour;
  logic       err_pulse;
`ifdef ANSI_DEC_STATS_EN
  logic [15:0] seq_count, err_count;
`endif

  always #5 clk = ~clk;

  ansi_colour_decoder dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_colour(out_colour), .out_valid(out_valid), .out_ready(out_ready),
    .cur_colour(cur_colour), .err_pulse(err_pulse)
`ifdef ANSI_DEC_STATS_EN
    , .seq_count(seq_count), .err_count(err_count)
`endif
  );

  int vec_cnt = 0;
  int miscmp  = 0;
  int err_seen = 0;
  logic [10:0] obs_q[$];
  logic [10:0] exp_q[$];
  logic [7:0]  stim[$];

  // Transfers and error pulses are sampled 2ns after the falling edge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (out_valid && out_ready) obs_q.push_back({out_colour, out_data});
      if (err_pulse) err_seen++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bit ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      #1;
      if (in_ready) ok = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_all();
    foreach (stim[i]) send(stim[i]);
    stim.delete();
  endtask

  task automatic flush();
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_out(input string tag, input int exp_err);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {21'd0, obs_q[i]}, {21'd0, exp_q[i]});
    check({tag, "_errs"}, err_seen, exp_err);
    obs_q.delete();
    exp_q.delete();
    err_seen = 0;
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_colour", out_colour, 0);
    check("rst_cur_colour", cur_colour, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // RED then reset-to-default via SGR 0
    stim = '{8'h1B, 8'h5B, 8'h33, 8'h31, 8'h6D};
    send_all(); #1;
    check("red_cur", cur_colour, 3);
    @(negedge clk);
    stim = '{8'h41, 8'h42, 8'h1B, 8'h5B, 8'h30, 8'h6D};
    send_all(); #1;
    check("sgr0_cur", cur_colour, 0);
    @(negedge clk);
    stim = '{8'h43};
    send_all(); flush();
    exp_q = '{{3'd3, 8'h41}, {3'd3, 8'h42}, {3'd0, 8'h43}};
    check_out("red", 0);

    // Unknown code 35
    stim = '{8'h1B, 8'h5B, 8'h33, 8'h35, 8'h6D, 8'h44};
    send_all(); flush();
    exp_q = '{{3'd0, 8'h44}};
    check_out("code35", 1);

    // Bad byte after ESC
    stim = '{8'h1B, 8'h58, 8'h45};
    send_all(); flush();
    exp_q = '{{3'd0, 8'h45}};
    check_out("escbad", 1);

    // Digit overflow
    stim = '{8'h1B, 8'h5B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h6D};
    send_all(); flush();
    check("ovf_cur", cur_colour, 0);
    check_out("ovf", 1);

    // ESC ESC restart, then GREEN; empty parameter returns to default
    stim = '{8'h1B, 8'h1B, 8'h5B, 8'h33, 8'h32, 8'h6D, 8'h46, 8'h1B, 8'h5B, 8'h6D, 8'h47};
    send_all(); flush();
    exp_q = '{{3'd4, 8'h46}, {3'd0, 8'h47}};
    check_out("escesc", 1);

    // ESC inside parameter restarts; 37 is WHITE; YELLOW via 33
    stim = '{8'h1B, 8'h5B, 8'h33, 8'h1B, 8'h5B, 8'h33, 8'h33, 8'h6D, 8'h48,
             8'h1B, 8'h5B, 8'h33, 8'h37, 8'h6D, 8'h49};
    send_all(); flush();
    exp_q = '{{3'd2, 8'h48}, {3'd0, 8'h49}};
    check_out("paramesc", 1);

    // Backpressure: hold first byte for 5 cycles
    out_ready = 1'b0;
    send(8'h41);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_in_ready%0d", c), in_ready, 0);
      check($sformatf("bp_valid%0d", c), out_valid, 1);
      check($sformatf("bp_data%0d", c), out_data, 8'h41);
      @(negedge clk);
    end
    out_ready = 1'b1;
    stim = '{8'h42, 8'h43};
    send_all(); flush();
    exp_q = '{{3'd0, 8'h41}, {3'd0, 8'h42}, {3'd0, 8'h43}};
    check_out("bp", 0);

    // BLUE, then reset mid-sequence
    stim = '{8'h1B, 8'h5B, 8'h39, 8'h34, 8'h6D, 8'h1B, 8'h5B, 8'h39};
    send_all(); #1;
    check("blue_cur", cur_colour, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_cur", cur_colour, 0);
`ifdef ANSI_DEC_STATS_EN
    check("rst2_seq_count", seq_count, 0);
    check("rst2_err_count", err_count, 0);
`endif
    @(negedge clk);
    obs_q.delete();
    err_seen = 0;
    stim = '{8'h34, 8'h6D};
    send_all(); flush();
    exp_q = '{{3'd0, 8'h34}, {3'd0, 8'h6D}};
    check_out("postrst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
